// File: rtl/ram_arbiter.sv
// ram_arbiter: two-master arbiter in front of the single data port of the
// byte-lane RAM. Master 0 (load/store unit) has default priority; master 1
// (debug bus) is forced through after STARVE_LIM consecutive lost cycles.
// Out-of-range accesses are absorbed here and answered with an error pulse.
module ram_arbiter #(
    parameter int unsigned RAM_AW     = 11,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              m0_req,
    input  logic [31:0]       m0_addr,
    input  logic              m0_we,
    input  logic [3:0]        m0_wstrb,
    input  logic [31:0]       m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic [31:0]       m1_addr,
    input  logic              m1_we,
    input  logic [3:0]        m1_wstrb,
    input  logic [31:0]       m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    output logic              m1_err,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int unsigned CNT_W    = 4;
    localparam logic [31:0]  WIN_SIZE = 32'(64'(4) << RAM_AW);
    localparam logic [CNT_W-1:0] LIM  = CNT_W'(STARVE_LIM);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             rd_pend_q, rd_pend_d;
    logic             rd_owner_q, rd_owner_d;
    logic             oor_q, oor_d;
    logic             err_q, err_d;

    logic        grant0, grant1, any_gnt;
    logic [31:0] sel_addr, sel_wdata, offset;
    logic        sel_we, in_range;
    logic [3:0]  sel_wstrb;
    logic [31:0] resp_data;

    // Winner selection, request mux, range check and RAM port drive
    always_comb begin
        grant1    = m1_req & (~m0_req | (starve_cnt_q == LIM));
        grant0    = m0_req & ~grant1;
        any_gnt   = grant0 | grant1;
        sel_addr  = grant1 ? m1_addr  : m0_addr;
        sel_we    = grant1 ? m1_we    : m0_we;
        sel_wstrb = grant1 ? m1_wstrb : m0_wstrb;
        sel_wdata = grant1 ? m1_wdata : m0_wdata;
        offset    = sel_addr - BASE_ADDR;
        in_range  = offset < WIN_SIZE;
        ram_en    = any_gnt & in_range;
        ram_we    = (ram_en & sel_we) ? sel_wstrb : 4'b0000;
        ram_addr  = offset[RAM_AW+1:2];
        ram_wdata = sel_wdata;
        m0_gnt    = grant0;
        m1_gnt    = grant1;
    end

    // Next-state: starvation counter and response pipeline
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!m1_req || grant1) begin
            starve_cnt_d = '0;
        end else if (grant0 && (starve_cnt_q != LIM)) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
        rd_pend_d  = any_gnt & ~sel_we;
        rd_owner_d = grant1;
        oor_d      = ~in_range;
        err_d      = any_gnt & ~in_range;
    end

    // State registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_cnt_q <= '0;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= 1'b0;
            oor_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rd_pend_q    <= rd_pend_d;
            rd_owner_q   <= rd_owner_d;
            oor_q        <= oor_d;
            err_q        <= err_d;
        end
    end

    // Route the response to the owning master; non-owners see zero data
    always_comb begin
        resp_data = oor_q ? 32'h0 : ram_rdata;
        m0_rvalid = rd_pend_q & ~rd_owner_q;
        m1_rvalid = rd_pend_q &  rd_owner_q;
        m0_rdata  = m0_rvalid ? resp_data : 32'h0;
        m1_rdata  = m1_rvalid ? resp_data : 32'h0;
        m0_err    = err_q & ~rd_owner_q;
        m1_err    = err_q &  rd_owner_q;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic against a transaction-level model.
module tb_ram_arbiter;

    localparam int unsigned AW    = 11;
    localparam int          WORDS = 2048;
    localparam int          LIM   = 4;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic          clk;
    logic          rstn;
    logic          r0, r1, we0, we1;
    logic [31:0]   a0, a1, d0, d1;
    logic [3:0]    s0, s1;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err;
    logic [31:0]   m0_rdata, m1_rdata;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    ram_arbiter #(.RAM_AW(AW), .BASE_ADDR(BASE), .STARVE_LIM(LIM)) dut (
        .clk(clk), .rstn(rstn),
        .m0_req(r0), .m0_addr(a0), .m0_we(we0), .m0_wstrb(s0), .m0_wdata(d0),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(r1), .m1_addr(a1), .m1_we(we1), .m1_wstrb(s1), .m1_wdata(d1),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(int i);
        if (i == 2) return 32'hAABB_CCDD;
        if (i == 4) return 32'hDEAD_BEEF;
        return 32'h1000_0000 | 32'(i);
    endfunction

    // Byte-lane RAM seen by the DUT: loads on the first edge, 1-cycle reads
    logic [31:0] ram_mem [WORDS];
    logic        loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < WORDS; i++) ram_mem[i] <= init_word(i);
            loaded <= 1'b1;
        end else if (ram_en) begin
            for (int l = 0; l < 4; l++)
                if (ram_we[l]) ram_mem[ram_addr][8*l +: 8] <= ram_wdata[8*l +: 8];
            if (ram_we == 4'b0000) ram_rdata <= ram_mem[ram_addr];
        end
    end

    // Reference model state
    logic [31:0] ref_mem [WORDS];
    int          m_cnt;
    logic        e_rv0, e_rv1, e_err0, e_err1;
    logic [31:0] e_rd;
    int          last_w;
    int          cyc;
    int          n_tests, n_fail;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // One clock cycle: check DUT against model mid-cycle, then advance model
    task automatic step();
        int          w, wi;
        logic        inr, we;
        logic [31:0] a, d, off;
        logic [3:0]  s;
        logic        n_rv0, n_rv1, n_e0, n_e1;
        logic [31:0] n_rd;
        @(negedge clk);
        w = -1;
        if (r0 && r1)  w = (m_cnt == LIM) ? 1 : 0;
        else if (r0)   w = 0;
        else if (r1)   w = 1;
        a   = (w == 1) ? a1  : a0;
        d   = (w == 1) ? d1  : d0;
        we  = (w == 1) ? we1 : we0;
        s   = (w == 1) ? s1  : s0;
        off = a - BASE;
        inr = off < 32'h2000;
        wi  = int'(off[12:2]);
        check("gnt0", 32'(m0_gnt), 32'(w == 0));
        check("gnt1", 32'(m1_gnt), 32'(w == 1));
        check("ram_en", 32'(ram_en), 32'(w >= 0 && inr));
        check("ram_we", 32'(ram_we), (w >= 0 && inr && we) ? 32'(s) : 32'h0);
        if (w >= 0 && inr) begin
            check("ram_addr", 32'(ram_addr), 32'(wi));
            check("ram_wdata", ram_wdata, d);
        end
        check("rvalid0", 32'(m0_rvalid), 32'(e_rv0));
        check("rvalid1", 32'(m1_rvalid), 32'(e_rv1));
        check("rdata0", m0_rdata, e_rv0 ? e_rd : 32'h0);
        check("rdata1", m1_rdata, e_rv1 ? e_rd : 32'h0);
        check("err0", 32'(m0_err), 32'(e_err0));
        check("err1", 32'(m1_err), 32'(e_err1));
        n_rv0 = (w == 0) && !we;
        n_rv1 = (w == 1) && !we;
        n_rd  = inr ? ref_mem[wi] : 32'h0;
        n_e0  = (w == 0) && !inr;
        n_e1  = (w == 1) && !inr;
        if (!r1 || w == 1)   m_cnt = 0;
        else if (m_cnt < LIM) m_cnt++;
        @(posedge clk);
        if (w >= 0 && we && inr)
            for (int l = 0; l < 4; l++)
                if (s[l]) ref_mem[wi][8*l +: 8] = d[8*l +: 8];
        e_rv0 = n_rv0; e_rv1 = n_rv1; e_rd = n_rd; e_err0 = n_e0; e_err1 = n_e1;
        last_w = w;
        cyc++;
        #1;
    endtask

    typedef struct {
        int          m;      // -1 idle, 0/1 single master, 2 both
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
        logic        x_en;
        logic [3:0]  x_we;
        logic [10:0] x_addr;
        logic        x_rv0, x_rv1;
        logic [31:0] x_rd;
        logic        x_e0, x_e1;
    } vec_t;

    function automatic vec_t mk(int m, logic we, logic [31:0] addr, logic [3:0] strb,
                                logic [31:0] data, logic en, logic [3:0] xwe,
                                logic [10:0] xaddr, logic rv0, logic rv1,
                                logic [31:0] rd, logic e0, logic e1);
        vec_t v;
        v.m = m; v.we = we; v.addr = addr; v.strb = strb; v.data = data;
        v.x_en = en; v.x_we = xwe; v.x_addr = xaddr; v.x_rv0 = rv0; v.x_rv1 = rv1;
        v.x_rd = rd; v.x_e0 = e0; v.x_e1 = e1;
        return v;
    endfunction

    function automatic logic [31:0] rnd_addr();
        if ($urandom_range(0, 15) == 0) return $urandom;
        return 32'($urandom_range(0, 32'h23FF));
    endfunction

    vec_t vecs [14];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0; n_fail = 0; cyc = 0; m_cnt = 0; last_w = -1;
        e_rv0 = 0; e_rv1 = 0; e_err0 = 0; e_err1 = 0; e_rd = 0;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
        rstn = 1'b0;
        r0 = 0; r1 = 0; we0 = 0; we1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0; s0 = 0; s1 = 0;

        vecs[0]  = mk(-1, 0, 32'h0,    4'h0, 32'h0,        0, 4'h0, 0, 0, 0, 32'h0,        0, 0);
        vecs[1]  = mk( 0, 0, 32'h10,   4'h0, 32'h0,        1, 4'h0, 4, 0, 0, 32'h0,        0, 0);
        vecs[2]  = mk( 1, 1, 32'h8,    4'h5, 32'h11223344, 1, 4'h5, 2, 1, 0, 32'hDEADBEEF, 0, 0);
        vecs[3]  = mk( 0, 0, 32'h8,    4'h0, 32'h0,        1, 4'h0, 2, 0, 0, 32'h0,        0, 0);
        vecs[4]  = mk(-1, 0, 32'h0,    4'h0, 32'h0,        0, 4'h0, 0, 1, 0, 32'hAA22CC44, 0, 0);
        vecs[5]  = mk( 0, 0, 32'h2000, 4'h0, 32'h0,        0, 4'h0, 0, 0, 0, 32'h0,        0, 0);
        vecs[6]  = mk( 0, 1, 32'h2004, 4'hF, 32'hFFFFFFFF, 0, 4'h0, 0, 1, 0, 32'h0,        1, 0);
        vecs[7]  = mk( 1, 0, 32'h4,    4'h0, 32'h0,        1, 4'h0, 1, 0, 0, 32'h0,        1, 0);
        vecs[8]  = mk( 0, 0, 32'h10,   4'h0, 32'h0,        1, 4'h0, 4, 0, 1, 32'h10000001, 0, 0);
        vecs[9]  = mk( 1, 0, 32'h10,   4'h0, 32'h0,        1, 4'h0, 4, 1, 0, 32'hDEADBEEF, 0, 0);
        vecs[10] = mk(-1, 0, 32'h0,    4'h0, 32'h0,        0, 4'h0, 0, 0, 1, 32'hDEADBEEF, 0, 0);
        vecs[11] = mk( 0, 1, 32'hC,    4'h0, 32'h55555555, 1, 4'h0, 3, 0, 0, 32'h0,        0, 0);
        vecs[12] = mk( 2, 0, 32'h0,    4'h0, 32'h0,        1, 4'h0, 0, 0, 0, 32'h0,        0, 0);
        vecs[13] = mk(-1, 0, 32'h0,    4'h0, 32'h0,        0, 4'h0, 0, 1, 0, 32'h10000000, 0, 0);

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        check("rst_rvalid0", 32'(m0_rvalid), 32'h0);
        check("rst_rvalid1", 32'(m1_rvalid), 32'h0);
        check("rst_err0", 32'(m0_err), 32'h0);
        check("rst_err1", 32'(m1_err), 32'h0);
        check("rst_gnt", 32'({m0_gnt, m1_gnt}), 32'h0);
        check("rst_ram_en", 32'(ram_en), 32'h0);
        rstn = 1'b1;

        // Directed vector table
        for (int i = 0; i < 14; i++) begin
            r0  = (vecs[i].m == 0) || (vecs[i].m == 2);
            r1  = (vecs[i].m == 1) || (vecs[i].m == 2);
            a0  = vecs[i].addr;  a1  = vecs[i].addr;
            we0 = vecs[i].we;    we1 = vecs[i].we;
            s0  = vecs[i].strb;  s1  = vecs[i].strb;
            d0  = vecs[i].data;  d1  = vecs[i].data;
            #2;
            check($sformatf("vec%0d_gnt0", i), 32'(m0_gnt), 32'(r0));
            check($sformatf("vec%0d_gnt1", i), 32'(m1_gnt), 32'(vecs[i].m == 1));
            check($sformatf("vec%0d_en", i), 32'(ram_en), 32'(vecs[i].x_en));
            check($sformatf("vec%0d_we", i), 32'(ram_we), 32'(vecs[i].x_we));
            if (vecs[i].x_en) check($sformatf("vec%0d_addr", i), 32'(ram_addr), 32'(vecs[i].x_addr));
            check($sformatf("vec%0d_rv0", i), 32'(m0_rvalid), 32'(vecs[i].x_rv0));
            check($sformatf("vec%0d_rv1", i), 32'(m1_rvalid), 32'(vecs[i].x_rv1));
            check($sformatf("vec%0d_rd0", i), m0_rdata, vecs[i].x_rv0 ? vecs[i].x_rd : 32'h0);
            check($sformatf("vec%0d_rd1", i), m1_rdata, vecs[i].x_rv1 ? vecs[i].x_rd : 32'h0);
            check($sformatf("vec%0d_err0", i), 32'(m0_err), 32'(vecs[i].x_e0));
            check($sformatf("vec%0d_err1", i), 32'(m1_err), 32'(vecs[i].x_e1));
            step();
        end

        // Continuous contention: m0 x4 then m1, repeating
        r0 = 1; r1 = 1; we0 = 0; we1 = 0; a0 = 32'h20; a1 = 32'h24;
        for (int i = 0; i < 10; i++) begin
            #2;
            check($sformatf("starve%0d_g1", i), 32'(m1_gnt), 32'((i % 5) == 4));
            check($sformatf("starve%0d_g0", i), 32'(m0_gnt), 32'((i % 5) != 4));
            step();
        end

        // Reset in the cycle after a read grant, with the counter part-way up
        r1 = 0; step();
        r1 = 1;
        for (int i = 0; i < 3; i++) step();
        r0 = 0; r1 = 0;
        check("pre_rst_rvalid0", 32'(m0_rvalid), 32'h1);
        rstn = 1'b0;
        #1;
        check("mid_rst_rvalid0", 32'(m0_rvalid), 32'h0);
        check("mid_rst_rvalid1", 32'(m1_rvalid), 32'h0);
        m_cnt = 0; e_rv0 = 0; e_rv1 = 0; e_err0 = 0; e_err1 = 0;
        @(posedge clk); #1;
        rstn = 1'b1;
        r0 = 1; r1 = 1;
        for (int i = 0; i < 5; i++) begin
            #2;
            check($sformatf("post_rst%0d_g1", i), 32'(m1_gnt), 32'(i == 4));
            step();
        end
        r0 = 0; r1 = 0; step();
        a0 = 32'h10; step();
        r0 = 1; step();
        r0 = 0; step();

        // Randomized traffic; a losing request is held until granted
        for (int i = 0; i < 1500; i++) begin
            if (!r0 || last_w == 0) begin
                r0 = ($urandom_range(0, 2) != 0); a0 = rnd_addr(); we0 = 1'($urandom_range(0, 1));
                s0 = 4'($urandom); d0 = $urandom;
            end
            if (!r1 || last_w == 1) begin
                r1 = ($urandom_range(0, 2) != 0); a1 = rnd_addr(); we1 = 1'($urandom_range(0, 1));
                s1 = 4'($urandom); d1 = $urandom;
            end
            step();
        end
        r0 = 0; r1 = 0; step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
